// File: rtl/itcm_fetch_resp.sv
// itcm_fetch_resp: instruction-fetch responder in front of a single-port, 1-cycle-latency ITCM SRAM
// Ports:
//   clk, rst_n                                  clock, asynchronous active-low reset
//   if_req_valid_i, if_req_ready_o, if_req_pc_i  fetch request channel
//   if_resp_valid_o, if_resp_ready_i,
//   if_resp_err_o, if_resp_instr_o               response channel, outputs driven from registers
//   flush_i                                     discard every outstanding request and response
//   itcm_cs_o, itcm_addr_o, itcm_rdata_i         SRAM read port, data valid the cycle after cs
module itcm_fetch_resp #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  ITCM_BASE   = 32'h8000_0000,
    parameter int unsigned          ITCM_AW     = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req_valid_i,
    output logic                   if_req_ready_o,
    input  logic [PC_WIDTH-1:0]    if_req_pc_i,
    output logic                   if_resp_valid_o,
    input  logic                   if_resp_ready_i,
    output logic                   if_resp_err_o,
    output logic [INSTR_WIDTH-1:0] if_resp_instr_o,
    input  logic                   flush_i,
    output logic                   itcm_cs_o,
    output logic [ITCM_AW-1:0]     itcm_addr_o,
    input  logic [INSTR_WIDTH-1:0] itcm_rdata_i
);
    // one extra bit so the upper limit of an ITCM ending at the top of the address space does not wrap
    localparam logic [PC_WIDTH:0] LO = {1'b0, ITCM_BASE};
    localparam logic [PC_WIDTH:0] HI = LO + ((PC_WIDTH + 1)'(1) << (ITCM_AW + 2));
    logic                   s1_vld, s1_err, wptr, rptr, acc, pop, push, err;
    logic [1:0]             cnt;
    logic [2:0]             occ;
    logic [PC_WIDTH:0]      pc_x;
    logic [INSTR_WIDTH:0]   mem [2];
    always_comb begin
        if_resp_valid_o = (cnt != 2'd0);
        {if_resp_err_o, if_resp_instr_o} = mem[rptr];
        pc_x = {1'b0, if_req_pc_i};
        err = (if_req_pc_i[1:0] != 2'b00) | (pc_x < LO) | (pc_x >= HI);
        pop = if_resp_valid_o & if_resp_ready_i;
        // a slot is reserved for the read in flight, so a push can never find the FIFO full
        occ = {1'b0, cnt} + {2'b00, s1_vld} - {2'b00, pop};
        if_req_ready_o = ~flush_i & (occ < 3'd2);
        acc = if_req_valid_i & if_req_ready_o;
        push = s1_vld & ~flush_i;
        itcm_cs_o = acc & ~err;
        itcm_addr_o = if_req_pc_i[ITCM_AW+1:2];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            s1_vld <= acc;
            s1_err <= acc & err;
            if (push)
                mem[wptr] <= {s1_err, itcm_rdata_i & {INSTR_WIDTH{~s1_err}}};
            wptr <= flush_i ? 1'b0 : wptr ^ push;
            rptr <= flush_i ? 1'b0 : rptr ^ pop;
            cnt  <= flush_i ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_itcm_fetch_resp.sv
// tb_itcm_fetch_resp: scoreboard bench for itcm_fetch_resp with a behavioural ITCM model
module tb_itcm_fetch_resp;
    logic        clk, rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_err, flush, cs;
    logic [31:0] req_pc, resp_instr, rdata;
    logic [13:0] addr;
    logic [31:0] sram [16384];
    logic [32:0] sb [$];
    logic [32:0] exp_r, prev_resp;
    logic        prev_hold, exp_cs;
    int          n_checks = 0;
    int          n_fail = 0;

    itcm_fetch_resp dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid_i(req_valid), .if_req_ready_o(req_ready), .if_req_pc_i(req_pc),
        .if_resp_valid_o(resp_valid), .if_resp_ready_i(resp_ready),
        .if_resp_err_o(resp_err), .if_resp_instr_o(resp_instr),
        .flush_i(flush), .itcm_cs_o(cs), .itcm_addr_o(addr), .itcm_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    // SRAM: data appears one cycle after cs; garbage otherwise so a mistimed capture shows up
    always @(posedge clk) rdata <= cs ? sram[addr] : 32'hDEAD_BEEF;

    function automatic logic is_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h8000_0000) || (pc >= 32'h8001_0000);
    endfunction

    function automatic logic [32:0] model(input logic [31:0] pc);
        return is_err(pc) ? {1'b1, 32'h0} : {1'b0, sram[pc[15:2]]};
    endfunction

    // scoreboard: push on accept, pop and compare on each completed response
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (resp_valid && resp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got err=%0b instr=%h, required no response", resp_err, resp_instr);
                end else begin
                    exp_r = sb.pop_front();
                    if ({resp_err, resp_instr} !== exp_r) begin
                        n_fail++;
                        $display("FAIL resp_data: got err=%0b instr=%h, required err=%0b instr=%h",
                                 resp_err, resp_instr, exp_r[32], exp_r[31:0]);
                    end
                end
            end
            if (prev_hold) begin
                n_checks++;
                if (!resp_valid || {resp_err, resp_instr} !== prev_resp) begin
                    n_fail++;
                    $display("FAIL resp_hold: got valid=%0b data=%h, required valid=1 data=%h",
                             resp_valid, {resp_err, resp_instr}, prev_resp);
                end
            end
            exp_cs = req_valid && req_ready && !is_err(req_pc);
            n_checks++;
            if (cs !== exp_cs) begin
                n_fail++;
                $display("FAIL itcm_cs: pc=%h got %0b, required %0b", req_pc, cs, exp_cs);
            end
            if (req_valid && req_ready) sb.push_back(model(req_pc));
            if (flush) sb.delete();
            prev_hold = resp_valid && !resp_ready && !flush;
            prev_resp = {resp_err, resp_instr};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
        cyc();
        cyc();
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: got valid=%0b, required 0", resp_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({resp_valid, resp_err, resp_instr, cs} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%0b err=%0b instr=%h cs=%0b, required all 0", resp_valid, resp_err, resp_instr, cs);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({resp_valid, resp_err, resp_instr, cs} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_held: got valid=%0b err=%0b instr=%h cs=%0b, required all 0", resp_valid, resp_err, resp_instr, cs);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4);
            req_pc = 32'h8000_0000 + 32'(4 * k);
            #1;
            if (k < 4) begin
                n_checks++;
                if (req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got %0b, required 1", k, req_ready);
                end
            end
            n_checks++;
            if (resp_valid !== (k >= 2)) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got valid=%0b, required %0b", k, resp_valid, k >= 2);
            end
            if (k >= 2) begin
                w = 32'(17 * (k - 1));
                n_checks++;
                if (resp_instr !== w) begin
                    n_fail++;
                    $display("FAIL b2b_instr[%0d]: got %h, required %h", k, resp_instr, w);
                end
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_faults();
        logic [31:0] pcs [6] = '{32'h8000_0010, 32'h7FFF_FFFC, 32'h8000_0014,
                                 32'h8001_0000, 32'h8000_0002, 32'h8000_FFFC};
        logic        ecs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1;
            req_pc = pcs[k];
            #1;
            n_checks++;
            if (cs !== ecs[k]) begin
                n_fail++;
                $display("FAIL fault_cs pc=%h: got %0b, required %0b", pcs[k], cs, ecs[k]);
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            req_valid = 1'b1;
            req_pc = 32'h8000_0100 + 32'(4 * (k < 2 ? k : 2));
            #1;
            n_checks++;
            if (req_ready !== (k < 2)) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %0b, required %0b", k, req_ready, k < 2);
            end
            if (k >= 2) begin
                n_checks++;
                if (cs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_cs[%0d]: got %0b, required 0", k, cs);
                end
            end
            cyc();
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_instr !== sram[14'h40]) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%0b instr=%h, required valid=1 instr=%h", resp_valid, resp_instr, sram[14'h40]);
        end
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %0b, required 1", req_ready);
        end
        cyc();
        drain();
    endtask

    task automatic test_flush();
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 32'h8000_0200;
        cyc();
        req_pc = 32'h8000_0204;
        cyc();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %0b, required 0", req_ready);
        end
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_valid[%0d]: got %0b, required 0", k, resp_valid);
            end
            cyc();
        end
        resp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc = 32'h8000_0208;
        cyc();
        req_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pop_valid: got %0b, required 0", resp_valid);
        end
        req_valid = 1'b1;
        req_pc = 32'h8000_0040;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_new_ready: got %0b, required 1", req_ready);
        end
        cyc();
        req_valid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_new_early: got valid=%0b, required 0", resp_valid);
        end
        cyc();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_instr !== sram[14'h10]) begin
            n_fail++;
            $display("FAIL flush_new_resp: got valid=%0b instr=%h, required valid=1 instr=%h", resp_valid, resp_instr, sram[14'h10]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 32'h8000_0300;
        cyc();
        req_pc = 32'h8000_0304;
        cyc();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, resp_err, resp_instr, cs} !== 35'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got valid=%0b err=%0b instr=%h cs=%0b, required all 0", resp_valid, resp_err, resp_instr, cs);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale[%0d]: got valid=%0b, required 0", k, resp_valid);
            end
            cyc();
        end
    endtask

    task automatic test_simul_push_pop();
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 32'h8000_0400;
        cyc();
        req_pc = 32'h8000_0404;
        cyc();
        req_valid = 1'b0;
        cyc();
        req_valid = 1'b1;
        req_pc = 32'h8000_0408;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_ready: got %0b, required 1", req_ready);
        end
        cyc();
        req_valid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_instr !== sram[14'h101]) begin
            n_fail++;
            $display("FAIL simul_second: got valid=%0b instr=%h, required valid=1 instr=%h", resp_valid, resp_instr, sram[14'h101]);
        end
        cyc();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_instr !== sram[14'h102]) begin
            n_fail++;
            $display("FAIL simul_third: got valid=%0b instr=%h, required valid=1 instr=%h", resp_valid, resp_instr, sram[14'h102]);
        end
        drain();
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_pc = 32'h0;
        resp_ready = 1'b0;
        flush = 1'b0;
        prev_hold = 1'b0;
        for (int i = 0; i < 16384; i++) sram[i] = (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        sram[0] = 32'h11;
        sram[1] = 32'h22;
        sram[2] = 32'h33;
        sram[3] = 32'h44;
        #1 rst_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_simul_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
